// File: rtl/axis_frame_limit.sv
// axis_frame_limit: AXI4-Stream frame-length enforcer with a one-deep registered output.
// Frames longer than max_len beats are cut short. The last allowed beat gets tlast forced
// high and is marked bad in tuser. The remaining input beats of that frame are discarded.
// Optional statistics counters are enabled by defining AXIS_FRAME_LIMIT_STATS_EN.
module axis_frame_limit #(
  parameter int                    DATA_WIDTH           = 8,
  parameter bit                    KEEP_ENABLE          = (DATA_WIDTH > 8),
  parameter int                    KEEP_WIDTH           = DATA_WIDTH / 8,
  parameter int                    ID_WIDTH             = 8,
  parameter int                    DEST_WIDTH           = 8,
  parameter int                    USER_WIDTH           = 1,
  parameter int                    LEN_WIDTH            = 16,
  parameter logic [USER_WIDTH-1:0] USER_BAD_FRAME_VALUE = USER_WIDTH'(1'b1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [ID_WIDTH-1:0]   s_axis_tid,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [ID_WIDTH-1:0]   m_axis_tid,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic [LEN_WIDTH-1:0]  max_len,
  output logic                  status_truncated,
  output logic                  status_frame,
  output logic [31:0]           stat_frame_count,
  output logic [31:0]           stat_trunc_count
);

  typedef enum logic {PASS, DROP} state_t;

  state_t               state;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [LEN_WIDTH-1:0] limit_reg;
  logic                 sof;        // next accepted beat begins a new frame
  logic [LEN_WIDTH-1:0] eff_limit;
  logic [LEN_WIDTH-1:0] cnt_next;
  logic                 accept;
  logic                 pass_beat;
  logic                 trunc;

  assign s_axis_tready = (state == DROP) | m_axis_tready | ~m_axis_tvalid;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign pass_beat     = accept & (state == PASS);
  // On the first beat the limit register is not yet loaded, so use max_len directly.
  assign eff_limit     = sof ? max_len : limit_reg;
  // Saturating increment keeps unlimited (limit 0) frames from wrapping the counter.
  assign cnt_next      = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;
  assign trunc         = pass_beat & (eff_limit != '0) & (cnt_next == eff_limit) & ~s_axis_tlast;

  // Frame tracking: PASS/DROP state, beat counter and latched per-frame limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PASS;
      beat_cnt  <= '0;
      limit_reg <= '0;
      sof       <= 1'b1;
    end else if (accept) begin
      if (sof) limit_reg <= max_len;
      if (state == PASS) begin
        if (s_axis_tlast) begin
          beat_cnt <= '0;
          sof      <= 1'b1;
        end else begin
          beat_cnt <= cnt_next;
          sof      <= 1'b0;
          if (trunc) state <= DROP;
        end
      end else if (s_axis_tlast) begin
        state    <= PASS;
        beat_cnt <= '0;
        sof      <= 1'b1;
      end
    end
  end

  // Output register: load forwarded beats, release once the sink takes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
      m_axis_tdest  <= '0;
      m_axis_tuser  <= '0;
    end else if (pass_beat) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tlast  <= s_axis_tlast | trunc;
      m_axis_tid    <= s_axis_tid;
      m_axis_tdest  <= s_axis_tdest;
      m_axis_tuser  <= trunc ? (s_axis_tuser | USER_BAD_FRAME_VALUE) : s_axis_tuser;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  generate
    if (KEEP_ENABLE) begin : g_keep
      // tkeep travels with the rest of the beat.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_axis_tkeep <= '0;
        else if (pass_beat) m_axis_tkeep <= s_axis_tkeep;
      end
    end else begin : g_no_keep
      assign m_axis_tkeep = '1;
    end
  endgenerate

  // Status pulses for the datapath monitor.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_truncated <= 1'b0;
      status_frame     <= 1'b0;
    end else begin
      status_truncated <= trunc;
      status_frame     <= m_axis_tvalid & m_axis_tready & m_axis_tlast;
    end
  end

`ifdef AXIS_FRAME_LIMIT_STATS_EN
  // Wrapping frame and truncation counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_frame_count <= 32'd0;
      stat_trunc_count <= 32'd0;
    end else begin
      if (m_axis_tvalid & m_axis_tready & m_axis_tlast) stat_frame_count <= stat_frame_count + 32'd1;
      if (trunc) stat_trunc_count <= stat_trunc_count + 32'd1;
    end
  end
`else
  assign stat_frame_count = 32'd0;
  assign stat_trunc_count = 32'd0;
`endif

endmodule

// File: tb/tb_axis_frame_limit.sv
// Testbench for axis_frame_limit: scoreboard of expected output beats, filled as stimulus
// is driven and drained by an output monitor.
module tb_axis_frame_limit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic [0:0]  s_keep;
  logic        s_valid;
  logic        s_ready;
  logic        s_last;
  logic [7:0]  s_id;
  logic [7:0]  s_dest;
  logic [0:0]  s_user;
  logic [7:0]  m_data;
  logic [0:0]  m_keep;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [7:0]  m_id;
  logic [7:0]  m_dest;
  logic [0:0]  m_user;
  logic [15:0] max_len;
  logic        status_truncated;
  logic        status_frame;
  logic [31:0] stat_frame_count;
  logic [31:0] stat_trunc_count;

  int n_tests = 0;
  int n_fail  = 0;
  int trunc_seen = 0;
  int frame_seen = 0;
  int exp_trunc = 0;
  int exp_frames = 0;

  logic [17:0] exp_q[$];   // {data, id, last, user}

  always #5 clk = ~clk;

  axis_frame_limit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axis_tdata     (s_data),
    .s_axis_tkeep     (s_keep),
    .s_axis_tvalid    (s_valid),
    .s_axis_tready    (s_ready),
    .s_axis_tlast     (s_last),
    .s_axis_tid       (s_id),
    .s_axis_tdest     (s_dest),
    .s_axis_tuser     (s_user),
    .m_axis_tdata     (m_data),
    .m_axis_tkeep     (m_keep),
    .m_axis_tvalid    (m_valid),
    .m_axis_tready    (m_ready),
    .m_axis_tlast     (m_last),
    .m_axis_tid       (m_id),
    .m_axis_tdest     (m_dest),
    .m_axis_tuser     (m_user),
    .max_len          (max_len),
    .status_truncated (status_truncated),
    .status_frame     (status_frame),
    .stat_frame_count (stat_frame_count),
    .stat_trunc_count (stat_trunc_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks stall stability.
  logic        hold = 1'b0;
  logic [18:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) check("stall_stable", {m_valid, m_data, m_id, m_last, m_user}, held);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", exp_q.size(), 1);
        end else begin
          logic [17:0] e;
          e = exp_q.pop_front();
          $display("[TB] out data=%h id=%h last=%b user=%b", m_data, m_id, m_last, m_user);
          check("beat", {m_data, m_id, m_last, m_user}, e);
        end
      end
      hold = m_valid && !m_ready;
      held = {m_valid, m_data, m_id, m_last, m_user};
      if (status_truncated) trunc_seen++;
      if (status_frame) frame_seen++;
    end
  end

  task automatic send_beat(input logic [7:0] d, input logic last);
    int t;
    s_valid = 1'b1;
    s_data  = d;
    s_id    = d ^ 8'h5A;
    s_dest  = ~d;
    s_last  = last;
    s_user  = 1'b0;
    t = 0;
    while (1) begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 200) begin
        check("s_ready_timeout", s_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  // Drives one frame of n beats and pushes the bench's own view of the output.
  task automatic send_frame(input int n, input logic [7:0] base, input logic [15:0] lim);
    bit cut;
    int keep_n;
    cut    = (lim != 0) && (n > lim);
    keep_n = cut ? int'(lim) : n;
    max_len = lim;
    exp_frames++;
    if (cut) exp_trunc++;
    for (int i = 0; i < n; i++) begin
      logic [7:0] d;
      logic       el;
      logic       eu;
      d  = base + 8'(i);
      el = (i == keep_n - 1);
      eu = cut && (i == keep_n - 1);
      if (i < keep_n) exp_q.push_back({d, d ^ 8'h5A, el, eu});
      $display("[TB] in  data=%h last=%b", d, (i == n - 1));
      send_beat(d, i == n - 1);
      // Any forwarded beat sits in the output register one cycle after acceptance.
      if (i < keep_n) check("latency", {m_valid, m_data, m_last, m_user}, {1'b1, d, el, eu});
    end
    max_len = 16'd4;
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_trunc_pulses"}, trunc_seen, exp_trunc);
    check({tag, "_frame_pulses"}, frame_seen, exp_frames);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_m_valid", m_valid, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_m_regs", {m_data, m_last, m_user, m_id, m_dest}, 0);
    check("reset_status", {status_truncated, status_frame}, 0);
    check("reset_stats", {stat_frame_count, stat_trunc_count}, 0);
    exp_q.delete();
    trunc_seen = 0;
    frame_seen = 0;
    exp_trunc  = 0;
    exp_frames = 0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef AXIS_FRAME_LIMIT_STATS_EN
    check({tag, "_frame_count"}, stat_frame_count, exp_frames);
    check({tag, "_trunc_count"}, stat_trunc_count, exp_trunc);
`else
    check({tag, "_frame_count"}, stat_frame_count, 0);
    check({tag, "_trunc_count"}, stat_trunc_count, 0);
`endif
  endtask

  initial begin
    rst_n   = 1'b1;
    s_valid = 1'b0;
    s_data  = '0;
    s_keep  = '1;
    s_last  = 1'b0;
    s_id    = '0;
    s_dest  = '0;
    s_user  = '0;
    m_ready = 1'b1;
    max_len = 16'd4;
    @(posedge clk);
    #1;
    do_reset();
    check("keep_all_ones", m_keep, 1);

    // 1: short frame passes through
    send_frame(3, 8'hA1, 16'd4);
    drain("t1");

    // 2: oversize frame truncated at 4 beats, tail dropped
    send_frame(7, 8'hB1, 16'd4);
    drain("t2");

    // 3: exact fit, then a normal frame
    send_frame(4, 8'hC1, 16'd4);
    send_frame(2, 8'hD1, 16'd4);
    drain("t3");

    // 4: unlimited frame with a toggling sink
    m_ready = 1'b0;
    fork
      send_frame(20, 8'h10, 16'd0);
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          m_ready = ~m_ready;
        end
      end
    join
    m_ready = 1'b1;
    drain("t4");
    check_stats("t4");

    // 5: reset in the middle of a frame, output stalled
    m_ready = 1'b0;
    max_len = 16'd2;
    send_beat(8'hE1, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'hE2;
    s_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t5_stalled_ready", s_ready, 0);
    s_valid = 1'b0;
    do_reset();
    m_ready = 1'b1;
    send_frame(2, 8'hF1, 16'd2);
    drain("t5");

    // 6: three good and two oversize frames counted from reset
    do_reset();
    send_frame(2, 8'h21, 16'd3);
    send_frame(3, 8'h31, 16'd3);
    send_frame(1, 8'h41, 16'd3);
    send_frame(5, 8'h51, 16'd3);
    send_frame(4, 8'h61, 16'd1);
    drain("t6");
    check_stats("t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
